// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  // Default coprocessor memory map (byte addresses)
  localparam logic [31:0] DEF_IN_BASE   = 32'h0004_0000;
  localparam logic [31:0] DEF_OUT_BASE  = 32'h0004_0404;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'h0004_F000;

  localparam int DEF_MAX_WORDS    = 256;
  localparam int DEF_READ_LATENCY = 2;
  localparam int DEF_POLL_TIMEOUT = 4096;

  // Control/status register bit positions
  localparam int CTRL_ENC  = 0;
  localparam int CTRL_DEC  = 1;
  localparam int CTRL_DONE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_POLL_ADDR,
    ST_POLL_WAIT,
    ST_DRAIN_ADDR,
    ST_DRAIN_WAIT,
    ST_DRAIN_HOLD
  } loader_state_t;

endpackage

// File: rtl/aes_stream_loader.sv
// Streams words into the AES coprocessor over MMIO, kicks it, polls done, streams results out.
// Latency: load 1 word/cycle; MMIO outputs registered (1 cycle); drain 1 word per READ_LATENCY+2 cycles.
// Backpressure: s_ready_out low outside IDLE/LOAD; results held stable until m_ready_in.
// Optional: AES_LOADER_TIMEOUT_EN adds a poll timeout that aborts with error_out set.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter logic [31:0] IN_BASE      = DEF_IN_BASE,
  parameter logic [31:0] OUT_BASE     = DEF_OUT_BASE,
  parameter logic [31:0] CTRL_ADDR    = DEF_CTRL_ADDR,
  parameter int          MAX_WORDS    = DEF_MAX_WORDS,
  parameter int          READ_LATENCY = DEF_READ_LATENCY,
  parameter int          POLL_TIMEOUT = DEF_POLL_TIMEOUT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] s_data_in,
  input  logic        s_valid_in,
  input  logic        s_last_in,
  output logic        s_ready_out,
  input  logic        mode_in,
  output logic [31:0] m_data_out,
  output logic        m_valid_out,
  output logic        m_last_out,
  input  logic        m_ready_in,
  output logic        busy_out,
  output logic        error_out,
  output logic [31:0] aes_addr_out,
  output logic [31:0] aes_data_out,
  output logic [3:0]  aes_we_out,
  input  logic [31:0] aes_data_in
);

  loader_state_t state, state_d;
  logic [8:0]  count, count_d, idx, idx_d;
  logic [1:0]  wcnt, wcnt_d;
  logic        mode, mode_d;
  logic        s_ready_d, m_valid_d, m_last_d, busy_d, error_d;
  logic [31:0] m_data_d, addr_d, wdata_d;
  logic [3:0]  we_d;
  logic        accept;

`ifdef AES_LOADER_TIMEOUT_EN
  localparam logic [11:0] POLL_LIMIT = 12'(POLL_TIMEOUT - 1);
  logic [11:0] pcnt, pcnt_d;
`endif

  assign accept = s_valid_in & s_ready_out;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d   = state;
    count_d   = count;
    idx_d     = idx;
    wcnt_d    = wcnt;
    mode_d    = mode;
    m_data_d  = m_data_out;
    m_valid_d = m_valid_out;
    m_last_d  = m_last_out;
    error_d   = error_out;
    addr_d    = aes_addr_out;
    wdata_d   = aes_data_out;
    we_d      = 4'h0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          mode_d  = mode_in;
          error_d = 1'b0;
          addr_d  = IN_BASE;
          wdata_d = s_data_in;
          we_d    = 4'hF;
          count_d = 9'd1;
          state_d = s_last_in ? ST_KICK : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          addr_d  = IN_BASE + {21'd0, count, 2'b00};
          wdata_d = s_data_in;
          we_d    = 4'hF;
          count_d = count + 9'd1;
          if (s_last_in) begin
            state_d = ST_KICK;
          end else if (count_d == 9'(MAX_WORDS)) begin
            // Buffer full without a last marker: truncate the block
            error_d = 1'b1;
            state_d = ST_KICK;
          end
        end
      end
      ST_KICK: begin
        addr_d  = CTRL_ADDR;
        wdata_d = mode ? (32'd1 << CTRL_DEC) : (32'd1 << CTRL_ENC);
        we_d    = 4'hF;
        state_d = ST_POLL_ADDR;
      end
      ST_POLL_ADDR: begin
        addr_d  = CTRL_ADDR;
        wcnt_d  = 2'd0;
        state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        // Read address becomes visible on entry here, so data lands READ_LATENCY cycles in
        if (wcnt == 2'(READ_LATENCY)) begin
          if (aes_data_in[CTRL_DONE]) begin
            idx_d   = 9'd0;
            addr_d  = OUT_BASE;
            state_d = ST_DRAIN_ADDR;
          end else begin
            state_d = ST_POLL_ADDR;
          end
        end else begin
          wcnt_d = wcnt + 2'd1;
        end
      end
      ST_DRAIN_ADDR: begin
        // Address was registered on the way in, so it is already on the bus this cycle
        wcnt_d  = 2'd0;
        state_d = ST_DRAIN_WAIT;
      end
      ST_DRAIN_WAIT: begin
        if (wcnt == 2'(READ_LATENCY - 1)) begin
          m_data_d  = aes_data_in;
          m_valid_d = 1'b1;
          m_last_d  = (idx == count - 9'd1);
          state_d   = ST_DRAIN_HOLD;
        end else begin
          wcnt_d = wcnt + 2'd1;
        end
      end
      ST_DRAIN_HOLD: begin
        if (m_ready_in) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_out) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx + 9'd1;
            addr_d  = OUT_BASE + {21'd0, idx + 9'd1, 2'b00};
            state_d = ST_DRAIN_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AES_LOADER_TIMEOUT_EN
    pcnt_d = pcnt;
    if (state == ST_KICK) begin
      pcnt_d = 12'd0;
    end else if (state == ST_POLL_ADDR || state == ST_POLL_WAIT) begin
      // A done seen on the final poll cycle still wins over the abort
      if (pcnt == POLL_LIMIT && state_d != ST_DRAIN_ADDR) begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        pcnt_d = pcnt + 12'd1;
      end
    end
`endif

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transfer in flight
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      count        <= 9'd0;
      idx          <= 9'd0;
      wcnt         <= 2'd0;
      mode         <= 1'b0;
      s_ready_out  <= 1'b0;
      m_data_out   <= 32'd0;
      m_valid_out  <= 1'b0;
      m_last_out   <= 1'b0;
      busy_out     <= 1'b0;
      error_out    <= 1'b0;
      aes_addr_out <= 32'd0;
      aes_data_out <= 32'd0;
      aes_we_out   <= 4'h0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      idx          <= idx_d;
      wcnt         <= wcnt_d;
      mode         <= mode_d;
      s_ready_out  <= s_ready_d;
      m_data_out   <= m_data_d;
      m_valid_out  <= m_valid_d;
      m_last_out   <= m_last_d;
      busy_out     <= busy_d;
      error_out    <= error_d;
      aes_addr_out <= addr_d;
      aes_data_out <= wdata_d;
      aes_we_out   <= we_d;
    end
  end

`ifdef AES_LOADER_TIMEOUT_EN
  // Poll timeout counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pcnt <= 12'd0;
    end else begin
      pcnt <= pcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader with a 2-cycle-read coprocessor stub.
// Stub raises done ~50 cycles after a control write; output word i = ~input word i.
// Covers encrypt, decrypt, backpressure, overflow, reset mid-poll and (optionally) poll timeout.
module tb_aes_stream_loader;
  import aes_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] s_data_in;
  logic        s_valid_in, s_last_in, s_ready_out, mode_in;
  logic [31:0] m_data_out;
  logic        m_valid_out, m_last_out, m_ready_in;
  logic        busy_out, error_out;
  logic [31:0] aes_addr_out, aes_data_out, aes_data_in;
  logic [3:0]  aes_we_out;

  aes_stream_loader dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_data_in(s_data_in), .s_valid_in(s_valid_in), .s_last_in(s_last_in),
    .s_ready_out(s_ready_out), .mode_in(mode_in),
    .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_last_out(m_last_out),
    .m_ready_in(m_ready_in), .busy_out(busy_out), .error_out(error_out),
    .aes_addr_out(aes_addr_out), .aes_data_out(aes_data_out),
    .aes_we_out(aes_we_out), .aes_data_in(aes_data_in)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // ---------------- coprocessor stub ----------------
  logic [31:0] in_mem [0:255];
  logic [31:0] rd1;
  logic        done;
  int          dcnt;
  bit          never_done = 1'b0;

  function automatic logic [31:0] stub_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - DEF_OUT_BASE;
    if (a == DEF_CTRL_ADDR) return {29'd0, done, 2'b00};
    if (a >= DEF_OUT_BASE && off < 32'd1024) return ~in_mem[off[9:2]];
    return 32'd0;
  endfunction

  always @(posedge clk_in) begin
    logic [31:0] woff;
    woff = aes_addr_out - DEF_IN_BASE;
    if (rst_in) begin
      done <= 1'b0; dcnt <= 0; rd1 <= 32'd0; aes_data_in <= 32'd0;
    end else begin
      rd1         <= stub_read(aes_addr_out);
      aes_data_in <= rd1;
      if (aes_we_out == 4'hF && aes_addr_out == DEF_CTRL_ADDR) begin
        done <= 1'b0;
        dcnt <= never_done ? 0 : 50;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) done <= 1'b1;
      end
      if (aes_we_out == 4'hF && aes_addr_out >= DEF_IN_BASE && woff < 32'd1024)
        in_mem[woff[9:2]] <= aes_data_out;
    end
  end

  // ---------------- bus / result monitors ----------------
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int vld_cnt = 0;
  int bad_we = 0;

  always @(posedge clk_in) begin
    if (!rst_in) begin
      if (m_valid_out) vld_cnt <= vld_cnt + 1;
      if (aes_we_out == 4'hF) begin
        wr_addr_q.push_back(aes_addr_out);
        wr_data_q.push_back(aes_data_out);
      end else if (aes_we_out != 4'h0) begin
        bad_we <= bad_we + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] blk [0:299];
  logic [31:0] exp_q [0:299];

  task automatic send_block(input int n, input logic mode, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t;
      s_valid_in = 1'b1;
      s_data_in  = blk[i];
      s_last_in  = with_last && (i == n - 1);
      mode_in    = mode;
      t = 0;
      while (!s_ready_out && t < 50) begin
        @(posedge clk_in); #1; t++;
      end
      if (!s_ready_out) begin
        check("send_ready", {31'd0, s_ready_out}, 32'd1);
        break;
      end
      @(posedge clk_in); #1;
    end
    s_valid_in = 1'b0;
    s_last_in  = 1'b0;
  endtask

  task automatic drain(input int n, input int hold_at, input string tag);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (!m_valid_out && t < 400) begin
        @(posedge clk_in); #1; t++;
      end
      if (!m_valid_out) begin
        check({tag, "_vld_timeout"}, 32'd0, 32'd1);
        return;
      end
      if (m_data_out !== exp_q[i]) check({tag, "_data"}, m_data_out, exp_q[i]);
      else if (m_last_out !== (i == n - 1)) check({tag, "_last"}, {31'd0, m_last_out}, {31'd0, i == n - 1});
      else if (i == 0 || i == n - 1) check({tag, "_data"}, m_data_out, exp_q[i]);
      if (i == hold_at) begin
        int bad;
        logic [31:0] held;
        bad  = 0;
        held = m_data_out;
        repeat (20) begin
          @(posedge clk_in); #1;
          if (m_data_out !== held || m_valid_out !== 1'b1) bad++;
        end
        check({tag, "_hold_bad_cycles"}, bad, 32'd0);
      end
      m_ready_in = 1'b1;
      @(posedge clk_in); #1;
      m_ready_in = 1'b0;
      if (m_valid_out !== 1'b0) check({tag, "_dead_cycle"}, {31'd0, m_valid_out}, 32'd0);
    end
    check({tag, "_idle_after"}, {31'd0, busy_out}, 32'd0);
  endtask

  task automatic check_writes(input int n, input logic [31:0] ctrl, input string tag);
    int bad;
    check({tag, "_wr_count"}, wr_addr_q.size(), n + 1);
    if (wr_addr_q.size() == n + 1) begin
      bad = 0;
      for (int i = 0; i < n; i++)
        if (wr_addr_q[i] !== DEF_IN_BASE + 32'(4 * i) || wr_data_q[i] !== blk[i]) bad++;
      check({tag, "_wr_words_bad"}, bad, 32'd0);
      check({tag, "_ctrl_addr"}, wr_addr_q[n], DEF_CTRL_ADDR);
      check({tag, "_ctrl_data"}, wr_data_q[n], ctrl);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, wr_mark, vld_mark, t;
    rst_in = 1'b1; s_data_in = 32'd0; s_valid_in = 1'b0; s_last_in = 1'b0;
    mode_in = 1'b0; m_ready_in = 1'b0;

    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", {31'd0, s_ready_out}, 32'd0);
    check("rst_misc", {27'd0, m_valid_out, m_last_out, busy_out, error_out, 1'b0}, 32'd0);
    check("rst_addr", aes_addr_out, 32'd0);
    check("rst_wdata_we", aes_data_out | {28'd0, aes_we_out}, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check("idle_ready", {31'd0, s_ready_out}, 32'd1);

    // Encrypt, 8 words
    blk[0] = 32'h6b2ee973; blk[1] = 32'hc1403d93; blk[2] = 32'h9a3b1cd4; blk[3] = 32'h12345678;
    blk[4] = 32'hdeadbeef; blk[5] = 32'h0badf00d; blk[6] = 32'ha5a5a5a5; blk[7] = 32'h579cac51;
    exp_q[0] = 32'h94d1168c; exp_q[1] = 32'h3ebfc26c; exp_q[2] = 32'h65c4e32b; exp_q[3] = 32'hedcba987;
    exp_q[4] = 32'h21524110; exp_q[5] = 32'hf4520ff2; exp_q[6] = 32'h5a5a5a5a; exp_q[7] = 32'ha86353ae;
    wr_addr_q.delete(); wr_data_q.delete();
    send_block(8, 1'b0, 1'b1);
    check("enc_busy", {31'd0, busy_out}, 32'd1);
    check("enc_ready_low", {31'd0, s_ready_out}, 32'd0);
    drain(8, -1, "enc");
    check_writes(8, 32'b001, "enc");

    // Backpressure on result 3 (index 2)
    wr_addr_q.delete(); wr_data_q.delete();
    vld_mark = vld_cnt;
    send_block(8, 1'b0, 1'b1);
    drain(8, 2, "bp");
    check_writes(8, 32'b001, "bp");

    // Overflow: 300 offered, 256 taken
    for (int i = 0; i < 300; i++) begin
      blk[i]   = (32'(i) * 32'h01010101) ^ 32'hC0FFEE00;
      exp_q[i] = ~blk[i];
    end
    wr_addr_q.delete(); wr_data_q.delete();
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      s_valid_in = 1'b1; s_data_in = blk[i]; s_last_in = 1'b0; mode_in = 1'b0;
      if (!s_ready_out) break;
      @(posedge clk_in); #1;
      acc++;
    end
    s_valid_in = 1'b0;
    check("ovf_accepted", acc, 32'd256);
    check("ovf_ready_low", {31'd0, s_ready_out}, 32'd0);
    check("ovf_error", {31'd0, error_out}, 32'd1);
    drain(256, -1, "ovf");
    check_writes(256, 32'b001, "ovf");
    check("ovf_error_sticky", {31'd0, error_out}, 32'd1);

    // Decrypt, single word; its accept also clears the overflow error
    blk[0] = 32'h3a0da824; exp_q[0] = 32'hc5f257db;
    wr_addr_q.delete(); wr_data_q.delete();
    send_block(1, 1'b1, 1'b1);
    check("dec_error_cleared", {31'd0, error_out}, 32'd0);
    drain(1, -1, "dec");
    check_writes(1, 32'b010, "dec");

    // Reset during POLL_WAIT
    send_block(1, 1'b0, 1'b1);
    t = 0;
    while (!(aes_we_out == 4'hF && aes_addr_out == DEF_CTRL_ADDR) && t < 20) begin
      @(posedge clk_in); #1; t++;
    end
    check("rstpoll_kick_seen", aes_addr_out, DEF_CTRL_ADDR);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("rstpoll_outs", {25'd0, s_ready_out, m_valid_out, m_last_out, busy_out, error_out, 2'b00}, 32'd0);
    check("rstpoll_bus", aes_addr_out | aes_data_out | {28'd0, aes_we_out}, 32'd0);
    wr_mark  = wr_addr_q.size();
    vld_mark = vld_cnt;
    repeat (100) @(posedge clk_in);
    #1;
    check("rstpoll_no_writes", wr_addr_q.size(), wr_mark);
    check("rstpoll_no_results", vld_cnt, vld_mark);
    check("rstpoll_idle", {30'd0, busy_out, s_ready_out}, 32'd1);

`ifdef AES_LOADER_TIMEOUT_EN
    never_done = 1'b1;
    vld_mark = vld_cnt;
    send_block(1, 1'b0, 1'b1);
    t = 0;
    while (busy_out && t < 5000) begin
      @(posedge clk_in); #1; t++;
    end
    check("to_idle", {31'd0, busy_out}, 32'd0);
    check("to_error", {31'd0, error_out}, 32'd1);
    check("to_no_results", vld_cnt, vld_mark);
    never_done = 1'b0;
`endif

    check("we_only_f_or_0", bad_we, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
